ram_loader: RTL and testbench
=============================

// Module: ram_loader
// PURPOSE
//  Initiator for the SN74x189 16xN RAM bank: streams words into consecutive RAM addresses
//  (LOAD) or reads them back and compares against a stream (VERIFY). Replaces DIP-switch
//  programming of the computer's memory. Drives a/cs_/we_/d and samples the inverted o_.
// PARAMETERS
//  N      8       data width (RAM bank width)
//  A      4       address width; DEPTH = 1<<A
// PORTS
//  clk        in   1    system clock, all state changes on posedge
//  reset      in   1    asynchronous, active-high
//  start      in   1    1-cycle request; sampled only in IDLE
//  mode       in   1    0=LOAD, 1=VERIFY; captured with start
//  base       in   A    first RAM address; captured with start
//  len        in   A+1  word count; captured with start; 0 = empty job
//  in_data    in   N    LOAD: word to write; VERIFY: expected word
//  in_valid   in   1    in_data valid
//  in_ready   out  1    word accepted when in_valid & in_ready
//  busy       out  1    high from cycle after start until done
//  done       out  1    1-cycle pulse, job finished
//  error      out  1    sticky VERIFY mismatch flag; cleared by next accepted start
//  err_addr   out  A    address of first mismatch of current job
//  ram_a      out  A    RAM address
//  ram_cs_    out  1    RAM chip select, active low
//  ram_we_    out  1    RAM write enable (RAM writes on falling edge of we_ & ~cs_)
//  ram_d      out  N    RAM write data
//  ram_o_     in   N    RAM inverted read data (Z when deselected)
// BEHAVIOUR
//  Reset (async): state IDLE; ram_cs_=1, ram_we_=0, ram_a=0, ram_d=0, in_ready=0,
//   busy=0, done=0, error=0, err_addr=0. All outputs registered.
//  RAM quirk: any fall of (we_ & ~cs_) writes ram_d. Rule: we_ parked low whenever cs_
//   toggles; every exit from we_=1 is a deliberate, safe write.
//  States: IDLE, FETCH, W_SET, W_ARM, W_STB, R_ADDR, R_READ, R_WB, R_CLOSE, DONE.
//  IDLE: start=1 -> capture mode/base/len, error/err_addr cleared, ptr=base, cnt=len;
//   len=0 -> DONE, else FETCH. start while busy ignored.
//  FETCH: ram_cs_=0, ram_we_=0, in_ready=1; hold until in_valid. On accept latch word,
//   go W_SET (LOAD) or R_ADDR (VERIFY). in_ready high only in FETCH.
//  LOAD per word (3 cycles): W_SET ram_a=ptr, ram_d=word, we_=0; W_ARM we_=1;
//   W_STB we_=0 (write occurs here; a/d held). Then ptr+1, cnt-1; cnt->0 ? DONE : FETCH.
//  VERIFY per word (4 cycles): R_ADDR ram_a=ptr, we_=0; R_READ we_=1, rd=~ram_o_ sampled
//   at end of cycle; R_WB ram_d=rd, we_=1; R_CLOSE we_=0 (rewrites identical rd, harmless).
//   rd!=expected and error=0 -> error=1, err_addr=ptr. Later mismatches keep first addr.
//  ptr wraps mod DEPTH (base+len>DEPTH wraps to 0; len>DEPTH rewrites/rechecks lowest).
//  DONE: ram_cs_=1, ram_we_=0, done=1 for one cycle, busy=0 next cycle, -> IDLE.
//  Throughput: LOAD 4 cycles/word, VERIFY 5 cycles/word with in_valid held high.
//  Reset mid-job: outputs return to idle values immediately; a reset during W_ARM or
//   R_READ/R_WB may write ram_d to current ram_a (only that address). Job abandoned,
//   no done pulse.
// TESTING
//  LOAD base=0 len=4 data 11,22,33,44 valid always -> RAM[0..3]=11..44, done at 17th cycle.
//  VERIFY base=0 len=4 exp 11,22,99,44 after above -> error=1, err_addr=2, RAM unchanged.
//  LOAD base=14 len=4 data A0..A3 -> RAM[14]=A0,[15]=A1,[0]=A2,[1]=A3 (wrap).
//  len=0 start -> done 1 cycle later, in_ready never high, RAM untouched.
//  in_valid low 5 cycles mid-LOAD -> FETCH stalls, cs_ low/we_ low, no extra writes.
//  start asserted while busy; async reset during W_STB -> ignored; outputs idle instantly.

Source files
------------

// File: rtl/ram_loader.sv
// ram_loader: streams words into, or verifies words against, an SN74x189-style
// 16xN RAM bank. The RAM writes on every fall of (we_ & ~cs_), so we_ is parked
// low whenever cs_ moves and each 1->0 of we_ is a deliberate write.
module ram_loader #(
  parameter int N = 8,
  parameter int A = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         mode,
  input  logic [A-1:0] base,
  input  logic [A:0]   len,
  input  logic [N-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic [A-1:0] err_addr,
  output logic [A-1:0] ram_a,
  output logic         ram_cs_,
  output logic         ram_we_,
  output logic [N-1:0] ram_d,
  input  logic [N-1:0] ram_o_
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    FETCH   = 4'd1,
    W_SET   = 4'd2,
    W_ARM   = 4'd3,
    W_STB   = 4'd4,
    R_ADDR  = 4'd5,
    R_READ  = 4'd6,
    R_WB    = 4'd7,
    R_CLOSE = 4'd8,
    DONE    = 4'd9
  } state_t;

  state_t       r_state, w_next;
  logic         r_mode, w_mode;
  logic [A-1:0] r_ptr, w_ptr;
  logic [A:0]   r_cnt, w_cnt;
  logic [N-1:0] r_word, w_word;
  logic         r_error, w_error;
  logic [A-1:0] r_err_addr, w_err_addr;
  logic [A-1:0] r_ram_a, w_ram_a;
  logic [N-1:0] r_ram_d, w_ram_d;
  logic         r_ram_cs_, w_ram_cs_;
  logic         r_ram_we_, w_ram_we_;
  logic         r_in_ready, w_in_ready;
  logic         r_busy, w_busy;
  logic         r_done, w_done;

  // Next-state and datapath: sequencing of the per-word bus cycles.
  always_comb begin
    w_next     = r_state;
    w_mode     = r_mode;
    w_ptr      = r_ptr;
    w_cnt      = r_cnt;
    w_word     = r_word;
    w_error    = r_error;
    w_err_addr = r_err_addr;
    w_ram_a    = r_ram_a;
    w_ram_d    = r_ram_d;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_mode     = mode;
          w_ptr      = base;
          w_cnt      = len;
          w_error    = 1'b0;
          w_err_addr = {A{1'b0}};
          w_next     = (len == {(A+1){1'b0}}) ? DONE : FETCH;
        end else begin
          w_next = IDLE;
        end
      end
      FETCH: begin
        if (in_valid) begin
          // Address (and write data for LOAD) are presented in the cycle after accept.
          w_word  = in_data;
          w_ram_a = r_ptr;
          if (r_mode) begin
            w_next = R_ADDR;
          end else begin
            w_ram_d = in_data;
            w_next  = W_SET;
          end
        end else begin
          w_next = FETCH;
        end
      end
      W_SET:  w_next = W_ARM;
      W_ARM:  w_next = W_STB;
      R_ADDR: w_next = R_READ;
      R_READ: begin
        // Inverted RAM output is read here and written back unchanged later.
        w_ram_d = ~ram_o_;
        w_next  = R_WB;
      end
      R_WB: begin
        if ((r_ram_d != r_word) && !r_error) begin
          w_error    = 1'b1;
          w_err_addr = r_ptr;
        end else begin
          w_error    = r_error;
        end
        w_next = R_CLOSE;
      end
      W_STB, R_CLOSE: begin
        w_ptr  = r_ptr + {{(A-1){1'b0}}, 1'b1};
        w_cnt  = r_cnt - {{A{1'b0}}, 1'b1};
        w_next = (r_cnt == {{A{1'b0}}, 1'b1}) ? DONE : FETCH;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Bus/handshake outputs as a function of the state being entered.
  always_comb begin
    w_ram_cs_  = 1'b0;
    w_ram_we_  = 1'b0;
    w_in_ready = 1'b0;
    w_busy     = 1'b1;
    w_done     = 1'b0;
    case (w_next)
      IDLE: begin
        w_ram_cs_ = 1'b1;
        w_busy    = 1'b0;
      end
      DONE: begin
        w_ram_cs_ = 1'b1;
        w_done    = 1'b1;
      end
      FETCH:                 w_in_ready = 1'b1;
      W_ARM, R_READ, R_WB:   w_ram_we_  = 1'b1;
      W_SET, W_STB, R_ADDR, R_CLOSE: w_ram_we_ = 1'b0;
      default: begin
        w_ram_cs_ = 1'b1;
        w_busy    = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset returns the bus to its idle values at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_mode     <= 1'b0;
      r_ptr      <= {A{1'b0}};
      r_cnt      <= {(A+1){1'b0}};
      r_word     <= {N{1'b0}};
      r_error    <= 1'b0;
      r_err_addr <= {A{1'b0}};
      r_ram_a    <= {A{1'b0}};
      r_ram_d    <= {N{1'b0}};
      r_ram_cs_  <= 1'b1;
      r_ram_we_  <= 1'b0;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_mode     <= w_mode;
      r_ptr      <= w_ptr;
      r_cnt      <= w_cnt;
      r_word     <= w_word;
      r_error    <= w_error;
      r_err_addr <= w_err_addr;
      r_ram_a    <= w_ram_a;
      r_ram_d    <= w_ram_d;
      r_ram_cs_  <= w_ram_cs_;
      r_ram_we_  <= w_ram_we_;
      r_in_ready <= w_in_ready;
      r_busy     <= w_busy;
      r_done     <= w_done;
    end
  end

  assign in_ready = r_in_ready;
  assign busy     = r_busy;
  assign done     = r_done;
  assign error    = r_error;
  assign err_addr = r_err_addr;
  assign ram_a    = r_ram_a;
  assign ram_cs_  = r_ram_cs_;
  assign ram_we_  = r_ram_we_;
  assign ram_d    = r_ram_d;

endmodule

// File: tb/tb_ram_loader.sv
// Bench for ram_loader: an edge-sensitive 74x189 model on the bus and a
// job-level reference (expected memory image, first-mismatch address, cycle cost).
module tb_ram_loader;
  logic       clk = 1'b0;
  logic       reset;
  logic       start, mode, in_valid;
  logic [3:0] base;
  logic [4:0] len;
  logic [7:0] in_data;
  logic       in_ready, busy, done, error;
  logic [3:0] err_addr, ram_a;
  logic       ram_cs_, ram_we_;
  logic [7:0] ram_d;
  wire  [7:0] ram_o_;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;

  logic [7:0] mem     [16];
  logic [7:0] exp_mem [16];
  logic [7:0] stream  [32];

  ram_loader #(.N(8), .A(4)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .base(base), .len(len),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .busy(busy),
    .done(done), .error(error), .err_addr(err_addr), .ram_a(ram_a),
    .ram_cs_(ram_cs_), .ram_we_(ram_we_), .ram_d(ram_d), .ram_o_(ram_o_)
  );

  always #5 clk = ~clk;

  // RAM model: outputs inverted data while selected in read mode, writes on fall of we_&~cs_.
  assign ram_o_ = (ram_cs_ === 1'b0 && ram_we_ === 1'b1) ? ~mem[ram_a] : 8'bz;
  logic w_wr, w_prev = 1'b0;
  assign w_wr = ram_we_ & ~ram_cs_;
  always @(w_wr) begin
    if (w_prev === 1'b1 && w_wr === 1'b0) begin
      mem[ram_a] = ram_d;
      wr_cnt++;
    end
    w_prev = w_wr;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, expv);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_cs"}, ram_cs_, 1'b1);
    chk({tag, "_we"}, ram_we_, 1'b0);
    chk({tag, "_a"}, ram_a, 4'd0);
    chk({tag, "_d"}, ram_d, 8'd0);
    chk({tag, "_rdy"}, in_ready, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_err"}, error, 1'b0);
    chk({tag, "_eaddr"}, err_addr, 4'd0);
  endtask

  task automatic chk_ram(input string tag);
    int bad = 0;
    for (int i = 0; i < 16; i++) if (mem[i] !== exp_mem[i]) bad++;
    chk(tag, bad, 0);
  endtask

  // stall: 0 = valid always, 1 = random gaps, 2 = five-cycle gap. rst_k: reset at that W_STB (-1 none).
  task automatic run_job(input logic m, input logic [3:0] b, input logic [4:0] l,
                         input int stall, input bit poke, input int rst_k);
    int cyc, idx, stbs, wr0, nwords;
    bit fin, aborted, ready_seen, prev_we, mis;
    logic [3:0] first_a, a;
    nwords = (rst_k >= 0) ? rst_k + 1 : int'(l);
    mis = 1'b0; first_a = 4'd0;
    for (int i = 0; i < nwords; i++) begin
      a = b + i[3:0];
      if (!m) exp_mem[a] = stream[i];
      else if (!mis && exp_mem[a] !== stream[i]) begin mis = 1'b1; first_a = a; end
    end
    @(negedge clk);
    start = 1'b1; mode = m; base = b; len = l; in_valid = 1'b0;
    wr0 = wr_cnt;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1'b1);
    cyc = 1; idx = 0; fin = 0; aborted = 0; stbs = 0; prev_we = 0; ready_seen = 0;
    while (!fin && cyc < 2000) begin
      if (in_ready) ready_seen = 1'b1;
      if (done) fin = 1'b1;
      else begin
        if (rst_k >= 0 && prev_we && !ram_we_ && !ram_cs_) begin
          if (stbs == rst_k) begin
            reset = 1'b1;
            #1;
            chk_idle("rst_mid");
            chk("rst_writes", wr_cnt - wr0, rst_k + 1);
            @(negedge clk);
            reset = 1'b0; in_valid = 1'b0;
            repeat (3) begin
              @(negedge clk);
              chk("rst_no_done", {done, busy}, 2'b00);
            end
            aborted = 1'b1; fin = 1'b1;
          end
          stbs++;
        end
        if (!aborted) begin
          prev_we = ram_we_;
          if (poke && cyc == 3) begin
            start = 1'b1; mode = ~m; base = b + 4'd5; len = 5'd1;
          end else begin
            start = 1'b0;
          end
          case (stall)
            1:       in_valid = ($urandom_range(0, 2) != 0);
            2:       in_valid = !(cyc >= 6 && cyc < 11);
            default: in_valid = 1'b1;
          endcase
          in_data = stream[idx];
          if (in_valid && in_ready) idx++;
          @(negedge clk);
          cyc++;
        end
      end
    end
    start = 1'b0; in_valid = 1'b0;
    if (!fin) chk("timeout", 0, 1);
    else if (!aborted) begin
      if (stall == 0) chk("done_cycle", cyc, (m ? 5 : 4) * int'(l) + 1);
      chk("error", error, mis);
      chk("err_addr", err_addr, first_a);
      chk("writes", wr_cnt - wr0, int'(l));
      if (l == 5'd0) chk("len0_ready", ready_seen, 1'b0);
      @(negedge clk);
      chk("done_pulse", done, 1'b0);
      chk("busy_end", busy, 1'b0);
      chk("error_sticky", error, mis);
    end
    chk_ram("ram_image");
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mode = 1'b0; base = 4'd0; len = 5'd0;
    in_data = 8'd0; in_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      mem[i] = 8'($urandom);
      exp_mem[i] = mem[i];
    end
    repeat (2) @(negedge clk);
    chk_idle("reset");
    reset = 1'b0;

    stream[0] = 8'h11; stream[1] = 8'h22; stream[2] = 8'h33; stream[3] = 8'h44;
    run_job(1'b0, 4'd0, 5'd4, 0, 1'b0, -1);
    stream[2] = 8'h99;
    run_job(1'b1, 4'd0, 5'd4, 0, 1'b0, -1);
    for (int i = 0; i < 4; i++) stream[i] = 8'hA0 + 8'(i);
    run_job(1'b0, 4'd14, 5'd4, 0, 1'b0, -1);
    run_job(1'b0, 4'd7, 5'd0, 0, 1'b0, -1);
    for (int i = 0; i < 6; i++) stream[i] = 8'($urandom);
    run_job(1'b0, 4'd3, 5'd6, 2, 1'b0, -1);
    for (int i = 0; i < 5; i++) stream[i] = 8'($urandom);
    run_job(1'b0, 4'd9, 5'd5, 0, 1'b1, -1);
    for (int i = 0; i < 4; i++) stream[i] = 8'($urandom);
    run_job(1'b0, 4'd5, 5'd4, 0, 1'b0, 1);

    for (int j = 0; j < 25; j++) begin
      logic       m;
      logic [3:0] b;
      logic [4:0] l;
      m = 1'($urandom);
      b = 4'($urandom);
      l = 5'($urandom_range(0, 20));
      for (int i = 0; i < 32; i++) begin
        if (m) stream[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : exp_mem[4'(b + i[3:0])];
        else   stream[i] = 8'($urandom);
      end
      run_job(m, b, l, $urandom_range(0, 1), 1'($urandom), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
